lenet_stage_sequencer: RTL and testbench

Run controller for the LeNet inference pipeline. It sequences the convolution stage (integrationConv) and the fully-connected stage (ANNfull) by driving their active-high stage resets. Each stage ends on an explicit done pulse or on a per-stage cycle budget, whichever comes first. A start/done handshake frames each inference, and the 4-bit class result is latched at completion. It replaces the hard-coded free-running cycle counter in the LeNet top level.

---
 rtl/lenet_seq_pkg.sv | 15 +
 rtl/lenet_stage_timer.sv | 27 ++
 rtl/lenet_stage_sequencer.sv | 120 ++++++++++++
 tb/tb_lenet_stage_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_seq_pkg.sv
// Shared state type and default budgets for the LeNet stage sequencer.
package lenet_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ANN,
    FIN
  } seq_state_t;

  localparam int CONV_CYCLES_DEF  = 122338;
  localparam int ANN_CYCLES_DEF   = 16384;
  localparam int RESULT_WIDTH_DEF = 4;

endpackage

// File: rtl/lenet_stage_timer.sv
// Stage cycle counter: cleared on stage entry, counts while enabled, and
// flags the final cycle of whichever budget is currently loaded.
module lenet_stage_timer #(
  parameter int CNT_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 expire
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign expire = (cnt == limit - CNT_WIDTH'(1));

endmodule

// File: rtl/lenet_stage_sequencer.sv
// Run controller sequencing the LeNet conv and ANN stages via their resets.
// Define LENET_SEQ_TIMEOUT_EN to build the sticky budget-expiry flag.
module lenet_stage_sequencer
  import lenet_seq_pkg::*;
#(
  parameter int CNT_WIDTH    = 18,
  parameter int CONV_CYCLES  = CONV_CYCLES_DEF,
  parameter int ANN_CYCLES   = ANN_CYCLES_DEF,
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    conv_done,
  input  logic                    ann_done,
  input  logic [RESULT_WIDTH-1:0] ann_result,
  output logic                    conv_reset,
  output logic                    ann_reset,
  output logic                    busy,
  output logic                    done,
  output logic [RESULT_WIDTH-1:0] result,
  output logic [CNT_WIDTH-1:0]    stage_cnt,
  output logic                    timeout
);

  seq_state_t           state, next_state;
  logic                 conv_reset_d, ann_reset_d, busy_d, done_d;
  logic                 timer_clear, timer_enable, expire;
  logic [CNT_WIDTH-1:0] limit;
  logic                 accept, ann_exit;

  assign limit    = (state == ANN) ? CNT_WIDTH'(ANN_CYCLES) : CNT_WIDTH'(CONV_CYCLES);
  assign accept   = (state == IDLE) && (next_state == CONV);
  assign ann_exit = (state == ANN) && (next_state == FIN);

  lenet_stage_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (limit),
    .cnt    (stage_cnt),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      conv_reset <= 1'b1;
      ann_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      conv_reset <= conv_reset_d;
      ann_reset  <= ann_reset_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Abort overrides stage completion; a done pulse and expiry on the same edge
  // still produce a single transition.
  always_comb begin
    next_state = state;
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = CONV;
        CONV:    if (conv_done || expire) next_state = ANN;
        ANN:     if (ann_done || expire) next_state = FIN;
        FIN:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // conv_reset stays low through ANN and FIN so the CNN output stays stable.
  always_comb begin
    conv_reset_d = (next_state == IDLE);
    ann_reset_d  = (next_state == IDLE) || (next_state == CONV);
    busy_d       = (next_state == CONV) || (next_state == ANN);
    done_d       = (next_state == FIN);
    timer_clear  = (next_state != state) || (state == IDLE) || (state == FIN);
    timer_enable = (state == CONV) || (state == ANN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
    end else if (accept) begin
      result <= '0;
    end else if (ann_exit) begin
      result <= ann_result;
    end
  end

`ifdef LENET_SEQ_TIMEOUT_EN
  logic conv_exit;

  assign conv_exit = (state == CONV) && (next_state == ANN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (accept) begin
      timeout <= 1'b0;
    end else if ((conv_exit && !conv_done) || (ann_exit && !ann_done)) begin
      timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lenet_stage_sequencer.sv
// Self-checking bench for lenet_stage_sequencer; expectations come from a
// per-inference timeline model (stage lengths, abort point, latched result).
module tb_lenet_stage_sequencer;

  localparam int CW     = 8;
  localparam int CONV_C = 10;
  localparam int ANN_C  = 5;
  localparam int RW     = 4;

`ifdef LENET_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    int conv_reset;
    int ann_reset;
    int busy;
    int done;
    int cnt;
    int result;
    int timeout;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, conv_done, ann_done;
  logic [RW-1:0] ann_result;
  logic          conv_reset, ann_reset, busy, done, timeout;
  logic [RW-1:0] result;
  logic [CW-1:0] stage_cnt;

  int checks = 0;
  int errors = 0;
  int curT = 0;

  int prevResult = 0;
  int prevTimeout = 0;
  int lc = CONV_C;
  int la = ANN_C;
  int abortAt = -1;
  int res = 0;
  bit convTo = 1'b0;
  bit annTo = 1'b0;
  int arRes[64];

  always #5 clk = ~clk;

  lenet_stage_sequencer #(
    .CNT_WIDTH    (CW),
    .CONV_CYCLES  (CONV_C),
    .ANN_CYCLES   (ANN_C),
    .RESULT_WIDTH (RW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .conv_done  (conv_done),
    .ann_done   (ann_done),
    .ann_result (ann_result),
    .conv_reset (conv_reset),
    .ann_reset  (ann_reset),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .stage_cnt  (stage_cnt),
    .timeout    (timeout)
  );

  // Expected outputs at cycle t of an inference (t=0 is the start cycle).
  function automatic exp_t baseAt(input int t);
    exp_t e;
    int   fin;
    fin          = lc + la + 1;
    e.conv_reset = 1;
    e.ann_reset  = 1;
    e.busy       = 0;
    e.done       = 0;
    e.cnt        = 0;
    e.result     = prevResult;
    e.timeout    = prevTimeout;
    if (t >= 1) begin
      e.result  = 0;
      e.timeout = 0;
    end
    if (t >= 1 && t <= lc) begin
      e.conv_reset = 0;
      e.busy       = 1;
      e.cnt        = t - 1;
    end else if (t > lc && t < fin) begin
      e.conv_reset = 0;
      e.ann_reset  = 0;
      e.busy       = 1;
      e.cnt        = t - lc - 1;
    end else if (t == fin) begin
      e.conv_reset = 0;
      e.ann_reset  = 0;
      e.done       = 1;
    end
    if (t > lc) e.timeout = (TO_EN && convTo) ? 1 : 0;
    if (t >= fin) begin
      e.result  = res;
      e.timeout = (TO_EN && (convTo || annTo)) ? 1 : 0;
    end
    return e;
  endfunction

  // After an abort the sequencer idles with result/timeout frozen at the abort cycle.
  function automatic exp_t expectAt(input int t);
    exp_t e;
    if (abortAt > 0 && t > abortAt) begin
      e            = baseAt(abortAt);
      e.conv_reset = 1;
      e.ann_reset  = 1;
      e.busy       = 0;
      e.done       = 0;
      e.cnt        = 0;
    end else begin
      e = baseAt(t);
    end
    return e;
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s t=%0d observed=%0d expected=%0d", tag, curT, obs, expv);
    end
  endtask

  task automatic checkOutput(input int t);
    exp_t e;
    e    = expectAt(t);
    curT = t;
    checkOne("conv_reset", 32'(conv_reset), e.conv_reset);
    checkOne("ann_reset", 32'(ann_reset), e.ann_reset);
    checkOne("busy", 32'(busy), e.busy);
    checkOne("done", 32'(done), e.done);
    checkOne("stage_cnt", 32'(stage_cnt), e.cnt);
    checkOne("result", 32'(result), e.result);
    checkOne("timeout", 32'(timeout), e.timeout);
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic c, input logic d,
                               input logic [RW-1:0] r);
    start      = s;
    abort      = a;
    conv_done  = c;
    ann_done   = d;
    ann_result = r;
  endtask

  // cd/ad: stage_cnt value at which the done pulse arrives (-1 = never),
  // ab: cycle whose closing edge sees abort (-1 = none), noisy: stray inputs.
  task automatic runInference(input int cd, input int ad, input int ab, input bit noisy);
    int total, stopT;
    lc      = (cd >= 0) ? cd + 1 : CONV_C;
    la      = (ad >= 0) ? ad + 1 : ANN_C;
    convTo  = (cd < 0);
    annTo   = (ad < 0);
    abortAt = ab;
    total   = lc + la + 3;
    stopT   = (ab > 0) ? ab : lc + la + 1;
    for (int i = 0; i < total; i++) arRes[i] = int'($urandom_range(0, 15));
    res = arRes[lc + la];
    for (int t = 0; t < total; t++) begin
      logic s, a, c, d;
      @(negedge clk);
      checkOutput(t);
      s = (t == 0) || (noisy && t >= 1 && t <= stopT && $urandom_range(0, 2) == 0);
      a = (t == ab);
      c = (cd >= 0 && t == cd + 1) || (noisy && t > lc && t <= lc + la && $urandom_range(0, 1) == 1);
      d = (ad >= 0 && t == lc + 1 + ad) || (noisy && t >= 1 && t <= lc && $urandom_range(0, 1) == 1);
      applyStimulus(s, a, c, d, RW'(arRes[t]));
    end
    begin
      exp_t e;
      e           = expectAt(total - 1);
      prevResult  = e.result;
      prevTimeout = e.timeout;
    end
    abortAt = -1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    checkOutput(0);
    reset = 1'b0;

    runInference(-1, -1, -1, 1'b0);
    runInference(3, 2, -1, 1'b0);
    runInference(-1, -1, CONV_C + 2, 1'b0);
    runInference(-1, -1, -1, 1'b1);
    runInference(CONV_C - 1, -1, -1, 1'b0);
    runInference(-1, 2, CONV_C + 3, 1'b0);
    runInference(4, -1, 3, 1'b1);
    runInference(2, 1, 6, 1'b0);
    runInference(0, 0, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int cd, ad, ab, fin;
      cd  = int'($urandom_range(0, CONV_C)) - 1;
      ad  = int'($urandom_range(0, ANN_C)) - 1;
      fin = ((cd >= 0) ? cd + 1 : CONV_C) + ((ad >= 0) ? ad + 1 : ANN_C) + 1;
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, fin)) : -1;
      runInference(cd, ad, ab, 1'b1);
    end

    // Asynchronous reset landing between edges in the middle of CONV.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    curT = -1;
    checkOne("busy_before_reset", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    prevResult  = 0;
    prevTimeout = 0;
    checkOutput(0);
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput(0);
    end
    reset = 1'b0;
    start = 1'b0;

    runInference(-1, -1, -1, 1'b0);

    $display("[TB] run complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
